// File: rtl/led_seq_ctrl_if.sv
// Config request channel for the LED sequencer: mode/speed offered by the
// board config logic under a valid/ready handshake.
interface led_seq_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [1:0] cfg_speed;

    modport master (output cfg_valid, output cfg_mode, output cfg_speed, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_mode, input cfg_speed, output cfg_ready);
endinterface

// File: rtl/led_seq_ctrl.sv
// 16-bit LED pattern sequencer: prescaled step tick, four patterns, and
// config changes that take effect only on a step boundary.
module led_seq_ctrl #(
    parameter int CNT_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pause,
    led_seq_ctrl_if.slave        cfg,
    output logic [15:0]          led,
    output logic                 step,
    output logic [1:0]           mode
);

    typedef enum logic {DIR_L, DIR_R} dir_t;

    localparam logic [1:0] M_SHIFT_L = 2'd0;
    localparam logic [1:0] M_SHIFT_R = 2'd1;
    localparam logic [1:0] M_BOUNCE  = 2'd2;

    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_led;
    logic [1:0]       r_mode;
    logic [1:0]       r_speed;
    dir_t             r_dir;
    logic             r_step;
    logic             r_pend;
    logic [1:0]       r_pend_mode;
    logic [1:0]       r_pend_speed;

    logic [CNT_W-1:0] w_mask;
    logic             w_tick;
    logic             w_xfer;
    logic             w_apply;
    logic             w_adv;
    logic [15:0]      w_led_nxt;
    dir_t             w_dir_nxt;

    function automatic logic [15:0] restart_led(input logic [1:0] m);
        case (m)
            M_SHIFT_L: return 16'h0001;
            M_SHIFT_R: return 16'h8000;
            M_BOUNCE:  return 16'h0001;
            default:   return 16'hFFFF;
        endcase
    endfunction

    // Faster speeds shorten the all-ones window, halving the period per step.
    assign w_mask  = {CNT_W{1'b1}} >> r_speed;
    assign w_tick  = !pause && ((r_cnt & w_mask) == w_mask);
    assign w_xfer  = cfg.cfg_valid && !r_pend;
    assign w_apply = w_tick && r_pend;
    assign w_adv   = w_tick && !r_pend;

    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir;
        if (w_apply) begin
            w_led_nxt = restart_led(r_pend_mode);
            w_dir_nxt = DIR_L;
        end else if (w_adv) begin
            case (r_mode)
                M_SHIFT_L: w_led_nxt = (r_led == 16'h8000) ? 16'h0001 : (r_led << 1);
                M_SHIFT_R: w_led_nxt = (r_led == 16'h0001) ? 16'h8000 : (r_led >> 1);
                M_BOUNCE: begin
                    if (r_dir == DIR_L) begin
                        if (r_led == 16'h8000) begin
                            w_led_nxt = 16'h4000;
                            w_dir_nxt = DIR_R;
                        end else begin
                            w_led_nxt = r_led << 1;
                        end
                    end else begin
                        if (r_led == 16'h0001) begin
                            w_led_nxt = 16'h0002;
                            w_dir_nxt = DIR_L;
                        end else begin
                            w_led_nxt = r_led >> 1;
                        end
                    end
                end
                default: w_led_nxt = ~r_led;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_led   <= 16'h0001;
            r_mode  <= M_SHIFT_L;
            r_speed <= 2'd0;
            r_dir   <= DIR_L;
            r_step  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_led  <= w_led_nxt;
            r_dir  <= w_dir_nxt;
            r_step <= w_tick;
            if (w_apply) begin
                r_cnt   <= '0;
                r_mode  <= r_pend_mode;
                r_speed <= r_pend_speed;
                r_pend  <= 1'b0;
            end else begin
                if (!pause) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_xfer) begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

    // Pending payload is qualified by r_pend, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_pend_mode  <= cfg.cfg_mode;
            r_pend_speed <= cfg.cfg_speed;
        end
    end

    assign cfg.cfg_ready = !r_pend;
    assign led           = r_led;
    assign step          = r_step;
    assign mode          = r_mode;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: expected step values and step spacing are
// queued as stimulus is driven and checked whenever the DUT pulses step.
module tb_led_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pause;
    logic [15:0] led;
    logic        step;
    logic [1:0]  mode;

    led_seq_ctrl_if cfg_if ();

    led_seq_ctrl #(.CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pause (pause),
        .cfg   (cfg_if),
        .led   (led),
        .step  (step),
        .mode  (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] led;
        logic [1:0]  mode;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [1:0] m, input int g);
        exp_t e;
        e.led  = l;
        e.mode = m;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    // Returns one time unit after the negedge that consumed the last entry.
    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_cfg(input logic [1:0] m, input logic [1:0] s);
        cfg_if.cfg_mode  = m;
        cfg_if.cfg_speed = s;
        cfg_if.cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
        chk("ready_low_after_xfer", cfg_if.cfg_ready, 0);
    endtask

    always @(negedge clk) begin
        if (step) begin
            if (exp_q.size() == 0) begin
                chk("spurious_step", step, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("led", led, e.led);
                chk("mode", mode, e.mode);
                if (e.gap != 0) chk("step_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] one;
        one = 16'h0001;
        rst_n = 1'b0;
        pause = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_mode  = 2'd0;
        cfg_if.cfg_speed = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", led, 16'h0001);
        chk("rst_mode", mode, 0);
        chk("rst_ready", cfg_if.cfg_ready, 1);
        chk("rst_step", step, 0);
        rst_n = 1'b1;

        // SHIFT_L speed 0: one step per 16 cycles, wraps 8000 -> 0001
        for (int k = 1; k <= 17; k++) push(one << (k % 16), 2'd0, (k == 1) ? 0 : 16);
        wait_drain(400);

        // BOUNCE speed 3, requested mid-period; applies on the old 16-cycle tick
        push(16'h0001, 2'd2, 16);
        for (int k = 1; k <= 15; k++) push(one << k, 2'd2, 2);
        for (int k = 14; k >= 0; k--) push(one << k, 2'd2, 2);
        push(16'h0002, 2'd2, 2);
        repeat (5) @(posedge clk);
        #1;
        do_cfg(2'd2, 2'd3);
        wait_drain(200);
        chk("ready_back_high", cfg_if.cfg_ready, 1);

        // SHIFT_R speed 1
        push(16'h8000, 2'd1, 2);
        for (int k = 14; k >= 0; k--) push(one << k, 2'd1, 8);
        push(16'h8000, 2'd1, 8);
        do_cfg(2'd1, 2'd1);
        wait_drain(200);

        // BLINK speed 2, then a 10-cycle pause that stretches one period
        push(16'hFFFF, 2'd3, 8);
        push(16'h0000, 2'd3, 4);
        push(16'hFFFF, 2'd3, 4);
        do_cfg(2'd3, 2'd2);
        wait_drain(60);
        push(16'h0000, 2'd3, 14);
        pause = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("pause_led_hold", led, 16'hFFFF);
            chk("pause_no_step", step, 0);
        end
        pause = 1'b0;
        push(16'hFFFF, 2'd3, 4);
        wait_drain(60);

        // Handshake while paused; second request with ready low is dropped
        push(16'h0001, 2'd0, 9);
        push(16'h0002, 2'd0, 2);
        push(16'h0004, 2'd0, 2);
        pause = 1'b1;
        do_cfg(2'd0, 2'd3);
        cfg_if.cfg_mode  = 2'd1;
        cfg_if.cfg_speed = 2'd1;
        cfg_if.cfg_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("ready_low_while_pending", cfg_if.cfg_ready, 0);
        chk("mode_not_pending", mode, 2'd3);
        cfg_if.cfg_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        pause = 1'b0;
        wait_drain(60);
        chk("ready_after_apply", cfg_if.cfg_ready, 1);

        // BOUNCE into dir=R, then reset while a BLINK request is pending
        push(16'h0001, 2'd2, 2);
        for (int k = 1; k <= 15; k++) push(one << k, 2'd2, 2);
        push(16'h4000, 2'd2, 2);
        do_cfg(2'd2, 2'd3);
        wait_drain(100);
        do_cfg(2'd3, 2'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_led", led, 16'h0001);
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_ready", cfg_if.cfg_ready, 1);
        chk("mid_rst_step", step, 0);
        push(16'h0002, 2'd0, 18);
        push(16'h0004, 2'd0, 16);
        wait_drain(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
